// File: rtl/pipo_shift_engine.sv
// pipo_shift_engine
//   Parallel-in/parallel-out register with a command-driven shift/rotate engine.
//   A command is accepted in IDLE. LOAD/CLEAR/NOP and zero-count shifts go straight
//   to DONE. Non-zero shifts step one bit per clock in SHIFT. DONE publishes the
//   working register on par_out and strobes out_valid for one cycle.
// Ports
//   clk, rst     clock and asynchronous active-high reset
//   cmd_valid    command present
//   cmd_ready    engine idle and able to accept (combinational)
//   cmd_op       000 NOP, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 CLEAR
//   cmd_cnt      number of 1-bit steps for the shift/rotate ops
//   data         parallel load word, sampled when a LOAD is accepted
//   ser_in       serial fill bit for SHL/SHR, sampled on every step
//   par_out      registered result word, held between strobes
//   ser_out      registered last bit shifted or rotated out
//   out_valid    one-cycle strobe marking a new par_out
//   busy         inverse of cmd_ready
module pipo_shift_engine #(
    parameter int LEN   = 8,
    parameter int CNT_W = $clog2(LEN) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [LEN-1:0]   data,
    input  logic             ser_in,
    output logic [LEN-1:0]   par_out,
    output logic             ser_out,
    output logic             out_valid,
    output logic             busy
);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
    localparam logic [2:0] OP_ROL   = 3'b100;
    localparam logic [2:0] OP_ROR   = 3'b101;
    localparam logic [2:0] OP_ASR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [LEN-1:0]   shift_reg;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] rem;
    logic             accept;
    logic             is_shift;
    logic             go_shift;
    logic [LEN-1:0]   step_reg;
    logic             step_ser;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = ~cmd_ready;
    assign accept    = cmd_valid & cmd_ready;
    assign is_shift  = (cmd_op >= OP_SHL) && (cmd_op <= OP_ASR);
    // A zero-count shift behaves like NOP: nothing to step, straight to DONE.
    assign go_shift  = is_shift && (cmd_cnt != '0);

    // One 1-bit step of the latched op applied to the working register.
    always_comb begin
        step_reg = shift_reg;
        step_ser = ser_out;
        unique case (op_q)
            OP_SHL: begin step_reg = {shift_reg[LEN-2:0], ser_in};         step_ser = shift_reg[LEN-1]; end
            OP_SHR: begin step_reg = {ser_in, shift_reg[LEN-1:1]};         step_ser = shift_reg[0];     end
            OP_ROL: begin step_reg = {shift_reg[LEN-2:0], shift_reg[LEN-1]}; step_ser = shift_reg[LEN-1]; end
            OP_ROR: begin step_reg = {shift_reg[0], shift_reg[LEN-1:1]};   step_ser = shift_reg[0];     end
            OP_ASR: begin step_reg = {shift_reg[LEN-1], shift_reg[LEN-1:1]}; step_ser = shift_reg[0];   end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept) state_nxt = go_shift ? S_SHIFT : S_DONE;
            S_SHIFT: if (rem == CNT_W'(1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            op_q      <= OP_NOP;
            rem       <= '0;
            par_out   <= '0;
            ser_out   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= 1'b0;
            unique case (state)
                S_IDLE: if (accept) begin
                    if (cmd_op == OP_LOAD)  shift_reg <= data;
                    if (cmd_op == OP_CLEAR) shift_reg <= '0;
                    if (go_shift) begin
                        op_q <= cmd_op;
                        rem  <= cmd_cnt;
                    end
                end
                S_SHIFT: begin
                    shift_reg <= step_reg;
                    ser_out   <= step_ser;
                    rem       <= rem - CNT_W'(1);
                end
                S_DONE: begin
                    par_out   <= shift_reg;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipo_shift_engine.sv
// Self-checking bench for pipo_shift_engine: directed scenarios plus randomized
// commands, checked against a bit-queue reference model of the register.
module tb_pipo_shift_engine;

    localparam int LEN   = 8;
    localparam int CNT_W = $clog2(LEN) + 1;

    localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                           ROL = 3'd4, ROR = 3'd5, ASR = 3'd6, CLR = 3'd7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = '0;
    logic [CNT_W-1:0] cmd_cnt = '0;
    logic [LEN-1:0]   data = '0;
    logic             ser_in = 1'b0;
    logic [LEN-1:0]   par_out;
    logic             ser_out;
    logic             out_valid;
    logic             busy;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [LEN-1:0] m_reg = '0;
    logic [LEN-1:0] m_par = '0;
    logic           m_ser = 1'b0;

    pipo_shift_engine #(.LEN(LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .data(data), .ser_in(ser_in),
        .par_out(par_out), .ser_out(ser_out), .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: the word is a queue of bits, MSB at the front. Shifts move bits
    // between the ends of the queue; the bit that leaves last is ser_out.
    task automatic model_cmd(input logic [2:0] op, input int cnt, input logic [LEN-1:0] d,
                             input logic sin);
        bit q[$];
        bit b;
        if (op == LOAD) m_reg = d;
        else if (op == CLR) m_reg = '0;
        else if (op != NOP) begin
            for (int i = LEN - 1; i >= 0; i--) q.push_back(m_reg[i]);
            for (int s = 0; s < cnt; s++) begin
                case (op)
                    SHL: begin m_ser = q.pop_front(); q.push_back(sin); end
                    SHR: begin m_ser = q.pop_back(); q.push_front(sin); end
                    ROL: begin b = q.pop_front(); m_ser = b; q.push_back(b); end
                    ROR: begin b = q.pop_back(); m_ser = b; q.push_front(b); end
                    default: begin m_ser = q.pop_back(); b = q[0]; q.push_front(b); end
                endcase
            end
            for (int i = 0; i < LEN; i++) m_reg[LEN-1-i] = q[i];
        end
        m_par = m_reg;
    endtask

    // Issue one command from the "#1 after posedge" phase and follow it to its
    // strobe. With junk=1, cmd_valid stays high with a bogus LOAD while busy.
    task automatic issue(input logic [2:0] op, input logic [CNT_W-1:0] cnt,
                         input logic [LEN-1:0] d, input logic sin, input bit junk);
        int w, lat, explat;
        logic [LEN-1:0] par0;
        bit stable;
        w = 0;
        while (!cmd_ready && w < 50) begin @(posedge clk); #1; w++; end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL ready_wait: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt; data = d; ser_in = sin;
        @(posedge clk); #1;
        model_cmd(op, int'(cnt), d, sin);
        if (junk) begin cmd_op = LOAD; data = ~d; end
        else cmd_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL strobe_width: out_valid=%b after accept, required 0", out_valid);
        end
        par0 = par_out; stable = 1'b1; lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1; lat++;
            if (out_valid === 1'b1) break;
            if (par_out !== par0) stable = 1'b0;
        end
        cmd_valid = 1'b0;
        explat = (op >= SHL && op <= ASR && cnt != 0) ? int'(cnt) + 1 : 1;
        checks++;
        if (lat != explat || out_valid !== 1'b1) begin
            errors++; $display("FAIL latency op=%0d cnt=%0d: got %0d (valid=%b) required %0d",
                               op, cnt, lat, out_valid, explat);
        end
        checks++;
        if (par_out !== m_par) begin
            errors++; $display("FAIL par_out op=%0d cnt=%0d: got %h required %h", op, cnt, par_out, m_par);
        end
        checks++;
        if (ser_out !== m_ser) begin
            errors++; $display("FAIL ser_out op=%0d cnt=%0d: got %b required %b", op, cnt, ser_out, m_ser);
        end
        checks++;
        if (!stable) begin
            errors++; $display("FAIL par_out_hold: par_out changed before strobe, required %h", par0);
        end
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL ready_in_strobe: cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (par_out !== '0 || ser_out !== 1'b0 || out_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_state: par=%h ser=%b v=%b rdy=%b busy=%b required 00 0 0 1 0",
                               par_out, ser_out, out_valid, cmd_ready, busy);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_rst_mid_shift();
        bit seen;
        issue(LOAD, '0, 8'h5B, 1'b0, 1'b0);
        cmd_valid = 1'b1; cmd_op = ROL; cmd_cnt = 5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (par_out !== '0 || ser_out !== 1'b0 || out_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_shift: par=%h ser=%b v=%b rdy=%b required 00 0 0 1",
                               par_out, ser_out, out_valid, cmd_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_reg = '0; m_par = '0; m_ser = 1'b0;
        seen = 1'b0;
        repeat (8) begin @(posedge clk); #1; if (out_valid === 1'b1) seen = 1'b1; end
        checks++;
        if (seen) begin
            errors++; $display("FAIL rst_abort: out_valid seen after reset, required none");
        end
        issue(NOP, '0, '0, 1'b0, 1'b0);
        checks++;
        if (par_out !== 8'h00) begin
            errors++; $display("FAIL rst_reg_cleared: par=%h required 00", par_out);
        end
    endtask

    task automatic test_load();
        issue(LOAD, '0, 8'hA5, 1'b1, 1'b0);
        checks++;
        if (par_out !== 8'hA5) begin
            errors++; $display("FAIL load_a5: par=%h required a5", par_out);
        end
    endtask

    task automatic test_rol();
        issue(LOAD, '0, 8'h81, 1'b0, 1'b0);
        issue(ROL, 3, 8'h00, 1'b1, 1'b0);
        checks++;
        if (par_out !== 8'h0C || ser_out !== 1'b0) begin
            errors++; $display("FAIL rol3: par=%h ser=%b required 0c 0", par_out, ser_out);
        end
    endtask

    task automatic test_asr_busy_ignore();
        issue(LOAD, '0, 8'h90, 1'b0, 1'b0);
        issue(ASR, 2, 8'h11, 1'b1, 1'b1);
        checks++;
        if (par_out !== 8'hE4 || ser_out !== 1'b0) begin
            errors++; $display("FAIL asr2: par=%h ser=%b required e4 0", par_out, ser_out);
        end
    endtask

    task automatic test_flush_and_zero();
        issue(LOAD, '0, 8'hFF, 1'b0, 1'b0);
        issue(SHR, 9, 8'h00, 1'b0, 1'b0);
        checks++;
        if (par_out !== 8'h00 || ser_out !== 1'b0) begin
            errors++; $display("FAIL shr9: par=%h ser=%b required 00 0", par_out, ser_out);
        end
        issue(LOAD, '0, 8'h6D, 1'b0, 1'b0);
        issue(SHL, 1, 8'h00, 1'b1, 1'b0);
        issue(SHL, 0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (par_out !== 8'hDB || ser_out !== 1'b0) begin
            errors++; $display("FAIL shl0: par=%h ser=%b required db 0", par_out, ser_out);
        end
    endtask

    task automatic test_back_to_back();
        issue(LOAD, '0, 8'h3C, 1'b0, 1'b0);
        checks++;
        if (par_out !== 8'h3C) begin
            errors++; $display("FAIL b2b_load: par=%h required 3c", par_out);
        end
        issue(CLR, '0, 8'hFF, 1'b0, 1'b0);
        checks++;
        if (par_out !== 8'h00) begin
            errors++; $display("FAIL b2b_clear: par=%h required 00", par_out);
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        for (int n = 0; n < 60; n++) begin
            op = 3'($urandom_range(0, 7));
            issue(op, CNT_W'($urandom_range(0, LEN + 4)), LEN'($urandom),
                  1'($urandom), bit'($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_rst_mid_shift();
        test_load();
        test_rol();
        test_asr_busy_ignore();
        test_flush_and_zero();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
